free_slot_manager: RTL and testbench
====================================

// Module: free_slot_manager
// PURPOSE
//  Owns a DEPTH-entry free bitmap (1 = free slot) and the release side of slot ownership.
//  Up to RELEASE_NUM release ports accept slot indices; each index is decoded to a one-hot mask
//    and ORed back into the bitmap.
//  The allocation port offers the lowest-numbered free index through a valid/ready handshake.
//  Sits beside the rename/ROB logic. Freed physical slots re-enter the pool here.
// PARAMETERS
//  DEPTH        32  number of slots; power of 2, >= 2
//  RELEASE_NUM  2   number of independent release ports, >= 1
//  IW           derived: max($clog2(DEPTH),1), index width
// PORTS
//  clk            in   1                 clock; all state updates on rising edge
//  rst            in   1                 asynchronous, active-high reset
//  flush          in   1                 synchronous restore: all slots free
//  alloc_ready    in   1                 consumer takes the offered index this cycle
//  alloc_valid    out  1                 at least one slot free (registered bitmap != 0)
//  alloc_index    out  IW                lowest free index; 0 when alloc_valid = 0
//  release_valid  in   RELEASE_NUM       per-port release strobe
//  release_index  in   RELEASE_NUM*IW    per-port index, port p at [p*IW +: IW]
//  free_count     out  $clog2(DEPTH)+1   number of set bits in the bitmap (registered)
//  full           out  1                 free_count == DEPTH (nothing allocated)
//  empty          out  1                 free_count == 0
//  double_rel_err out  1                 sticky: released an already-free slot
// BEHAVIOUR
//  Reset (async assert, sync use): bitmap = all ones, free_count = DEPTH, full = 1.
//    Also empty = 0, alloc_valid = 1, alloc_index = 0, double_rel_err = 0.
//  alloc_valid and alloc_index are combinational from the registered bitmap only.
//    The lowest set bit wins. Neither output depends on same-cycle releases.
//  Alloc fire = alloc_valid & alloc_ready: clear bit alloc_index at the next edge.
//    alloc_ready while alloc_valid = 0 is ignored.
//  Release: for each p with release_valid[p], set bit release_index[p] at the next edge.
//    A released slot becomes allocatable in the cycle after release (1-cycle latency).
//  Next bitmap = (bitmap & ~alloc_mask) | release_mask. Release wins over alloc on the same bit.
//    The same-bit case can only occur on an erroneous release.
//  Two ports releasing the same index in one cycle set the bit once; free_count rises by 1.
//    This also sets double_rel_err.
//  double_rel_err sets when a released index is already free, or duplicates another port's index.
//    It clears only on rst; flush does not clear it.
//  free_count next = popcount(next bitmap). It must equal the incremental update.
//    It never exceeds DEPTH and never underflows below 0.
//  flush has priority over alloc and release in the same cycle.
//    Next bitmap = all ones, free_count = DEPTH, and the fire is discarded.
//  Empty boundary: when the last slot is allocated, alloc_valid = 0 the next cycle.
//    A release in the same cycle as the last alloc leaves alloc_valid = 1 the next cycle.
//  Reset mid-operation: state returns to the reset values immediately; pending inputs are dropped.
// TESTING
//  DEPTH=8, RELEASE_NUM=2 unless stated; checker compares against a bitmap/popcount model.
//  1) Post-reset, alloc_ready=1 for 8 cycles -> indices 0..7 in order.
//     Then empty=1, alloc_valid=0, free_count=0.
//  2) From empty: release 5 and 2 on ports 0/1 in one cycle.
//     -> Next cycle free_count=2, alloc_index=2; after one fire, alloc_index=5.
//  3) One slot free (idx 3): alloc fires while port0 releases 6 in the same cycle.
//     -> Next cycle alloc_valid=1, alloc_index=6, free_count=1.
//  4) Both ports release 4 when 4 is allocated -> free_count +1, double_rel_err=1.
//     Releasing free slot 0 -> double_rel_err=1 and the bitmap is unchanged.
//  5) With 3 slots allocated: flush + alloc fire + release 1 in the same cycle.
//     -> Bitmap 8'hFF, free_count=8, full=1, double_rel_err holds its value.
//  6) Assert rst asynchronously mid-cycle during allocation.
//     -> Outputs reach reset values before the next edge; random alloc/release soak for 10k cycles shows no mismatch.

Source files
------------

// File: rtl/free_slot_manager.sv
// Free-slot bitmap with lowest-index allocation and multi-port release.
// Freed slots return to the pool one cycle after release; double releases raise a sticky flag.
module free_slot_manager #(
  parameter int DEPTH       = 32,
  parameter int RELEASE_NUM = 2,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      alloc_ready,
  output logic                      alloc_valid,
  output logic [IW-1:0]             alloc_index,
  input  logic [RELEASE_NUM-1:0]    release_valid,
  input  logic [RELEASE_NUM*IW-1:0] release_index,
  output logic [CW-1:0]             free_count,
  output logic                      full,
  output logic                      empty,
  output logic                      double_rel_err
);

  logic [DEPTH-1:0] bitmap_q, bitmap_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;

  logic [DEPTH-1:0] alloc_mask;
  logic [DEPTH-1:0] release_mask;
  logic [DEPTH-1:0] port_mask;
  logic             rel_err;
  logic             fire;

  // Lowest set bit wins: scan from the top so the last hit is the lowest index.
  always_comb begin
    alloc_index = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (bitmap_q[i]) alloc_index = IW'(i);
    end
  end

  assign alloc_valid = |bitmap_q;
  assign fire        = alloc_valid & alloc_ready;

  always_comb begin
    alloc_mask = '0;
    if (fire) alloc_mask = DEPTH'(1) << alloc_index;
  end

  // A release is erroneous if the slot is already free or another port names it too.
  always_comb begin
    release_mask = '0;
    port_mask    = '0;
    rel_err      = 1'b0;
    for (int p = 0; p < RELEASE_NUM; p++) begin
      if (release_valid[p]) begin
        port_mask = DEPTH'(1) << release_index[p*IW +: IW];
        if ((bitmap_q & port_mask) != '0)     rel_err = 1'b1;
        if ((release_mask & port_mask) != '0) rel_err = 1'b1;
        release_mask = release_mask | port_mask;
      end
    end
  end

  always_comb begin
    if (flush) begin
      bitmap_d = '1;
      err_d    = err_q;
    end else begin
      bitmap_d = (bitmap_q & ~alloc_mask) | release_mask;
      err_d    = err_q | rel_err;
    end
    count_d = CW'($countones(bitmap_d));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitmap_q <= '1;
      count_q  <= CW'(DEPTH);
      err_q    <= 1'b0;
    end else begin
      bitmap_q <= bitmap_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign free_count     = count_q;
  assign full           = (count_q == CW'(DEPTH));
  assign empty          = (count_q == '0);
  assign double_rel_err = err_q;

endmodule

// File: tb/tb_free_slot_manager.sv
// Self-checking bench for free_slot_manager (DEPTH=8, RELEASE_NUM=2) against a bitmap model.
module tb_free_slot_manager;

  localparam int DEPTH = 8;
  localparam int RN    = 2;
  localparam int IW    = 3;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          alloc_ready = 1'b0;
  logic          alloc_valid;
  logic [IW-1:0] alloc_index;
  logic [RN-1:0] release_valid = '0;
  logic [RN*IW-1:0] release_index = '0;
  logic [CW-1:0] free_count;
  logic          full, empty, double_rel_err;

  int checks = 0;
  int failures = 0;

  logic [DEPTH-1:0] m_bm;
  logic             m_err;

  free_slot_manager #(.DEPTH(DEPTH), .RELEASE_NUM(RN)) dut (
    .clk(clk), .rst(rst), .flush(flush), .alloc_ready(alloc_ready),
    .alloc_valid(alloc_valid), .alloc_index(alloc_index),
    .release_valid(release_valid), .release_index(release_index),
    .free_count(free_count), .full(full), .empty(empty),
    .double_rel_err(double_rel_err)
  );

  always #5 clk = ~clk;

  function automatic int m_lowest(input logic [DEPTH-1:0] bm);
    for (int i = 0; i < DEPTH; i++) if (bm[i]) return i;
    return 0;
  endfunction

  function automatic int m_count(input logic [DEPTH-1:0] bm);
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (bm[i]) n++;
    return n;
  endfunction

  // Drives one cycle of inputs, advances the model across the rising edge, returns at negedge.
  task automatic tick(input logic fl, input logic ar, input logic [1:0] rv,
                      input logic [2:0] r0, input logic [2:0] r1);
    logic [DEPTH-1:0] nb;
    logic             ne;
    int               idx [2];
    flush = fl; alloc_ready = ar; release_valid = rv; release_index = {r1, r0};
    idx[0] = r0; idx[1] = r1;
    nb = m_bm;
    ne = m_err;
    if (ar && m_bm != 0) nb[m_lowest(m_bm)] = 1'b0;
    for (int p = 0; p < RN; p++) begin
      if (rv[p]) begin
        if (m_bm[idx[p]]) ne = 1'b1;
        if (p == 1 && rv[0] && idx[0] == idx[1]) ne = 1'b1;
        nb[idx[p]] = 1'b1;
      end
    end
    if (fl) begin
      nb = '1;
      ne = m_err;
    end
    @(posedge clk);
    m_bm = nb;
    m_err = ne;
    @(negedge clk);
    flush = 1'b0; alloc_ready = 1'b0; release_valid = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    flush = 1'b0; alloc_ready = 1'b0; release_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    m_bm = '1;
    m_err = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({alloc_valid, alloc_index, free_count, full, empty, double_rel_err} !==
        {1'b1, 3'd0, 4'd8, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset: valid=%0b idx=%0d cnt=%0d full=%0b empty=%0b err=%0b, want 1 0 8 1 0 0",
               alloc_valid, alloc_index, free_count, full, empty, double_rel_err);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (alloc_valid !== 1'b1 || alloc_index !== IW'(i)) begin
        failures++;
        $display("FAIL drain_order: valid=%0b idx=%0d, want 1 %0d", alloc_valid, alloc_index, i);
      end
      tick(1'b0, 1'b1, 2'b00, 3'd0, 3'd0);
    end
    checks++;
    if (empty !== 1'b1 || alloc_valid !== 1'b0 || free_count !== 4'd0 || alloc_index !== 3'd0 || full !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty: empty=%0b valid=%0b cnt=%0d idx=%0d full=%0b, want 1 0 0 0 0",
               empty, alloc_valid, free_count, alloc_index, full);
    end
  endtask

  task automatic test_dual_release();
    tick(1'b0, 1'b1, 2'b11, 3'd5, 3'd2);
    checks++;
    if (free_count !== 4'd2 || alloc_index !== 3'd2 || alloc_valid !== 1'b1) begin
      failures++;
      $display("FAIL dual_release: cnt=%0d idx=%0d valid=%0b, want 2 2 1", free_count, alloc_index, alloc_valid);
    end
    tick(1'b0, 1'b1, 2'b00, 3'd0, 3'd0);
    checks++;
    if (alloc_index !== 3'd5 || free_count !== 4'd1) begin
      failures++;
      $display("FAIL dual_release_next: idx=%0d cnt=%0d, want 5 1", alloc_index, free_count);
    end
  endtask

  task automatic test_alloc_release_same();
    tick(1'b0, 1'b1, 2'b01, 3'd3, 3'd0);
    checks++;
    if (alloc_index !== 3'd3 || free_count !== 4'd1) begin
      failures++;
      $display("FAIL swap_setup: idx=%0d cnt=%0d, want 3 1", alloc_index, free_count);
    end
    tick(1'b0, 1'b1, 2'b01, 3'd6, 3'd0);
    checks++;
    if (alloc_valid !== 1'b1 || alloc_index !== 3'd6 || free_count !== 4'd1 || double_rel_err !== 1'b0) begin
      failures++;
      $display("FAIL last_alloc_with_release: valid=%0b idx=%0d cnt=%0d err=%0b, want 1 6 1 0",
               alloc_valid, alloc_index, free_count, double_rel_err);
    end
  endtask

  task automatic test_double_release();
    do_reset();
    tick(1'b0, 1'b0, 2'b01, 3'd0, 3'd0);
    checks++;
    if (double_rel_err !== 1'b1 || free_count !== 4'd8 || full !== 1'b1 || alloc_index !== 3'd0) begin
      failures++;
      $display("FAIL release_free_slot: err=%0b cnt=%0d full=%0b idx=%0d, want 1 8 1 0",
               double_rel_err, free_count, full, alloc_index);
    end
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 2'b00, 3'd0, 3'd0);
    checks++;
    if (free_count !== 4'd3 || double_rel_err !== 1'b0) begin
      failures++;
      $display("FAIL dup_setup: cnt=%0d err=%0b, want 3 0", free_count, double_rel_err);
    end
    tick(1'b0, 1'b0, 2'b11, 3'd4, 3'd4);
    checks++;
    if (free_count !== 4'd4 || double_rel_err !== 1'b1 || alloc_index !== 3'd4) begin
      failures++;
      $display("FAIL dup_release: cnt=%0d err=%0b idx=%0d, want 4 1 4", free_count, double_rel_err, alloc_index);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 2'b00, 3'd0, 3'd0);
    tick(1'b0, 1'b0, 2'b10, 3'd0, 3'd7);
    checks++;
    if (free_count !== 4'd5 || double_rel_err !== 1'b1 || alloc_index !== 3'd3) begin
      failures++;
      $display("FAIL flush_setup: cnt=%0d err=%0b idx=%0d, want 5 1 3", free_count, double_rel_err, alloc_index);
    end
    tick(1'b1, 1'b1, 2'b01, 3'd1, 3'd0);
    checks++;
    if (free_count !== 4'd8 || full !== 1'b1 || alloc_index !== 3'd0 || double_rel_err !== 1'b1) begin
      failures++;
      $display("FAIL flush: cnt=%0d full=%0b idx=%0d err=%0b, want 8 1 0 1",
               free_count, full, alloc_index, double_rel_err);
    end
  endtask

  task automatic test_async_reset();
    tick(1'b0, 1'b1, 2'b00, 3'd0, 3'd0);
    tick(1'b0, 1'b1, 2'b00, 3'd0, 3'd0);
    alloc_ready = 1'b1;
    release_valid = 2'b01;
    release_index = 6'd2;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({alloc_valid, alloc_index, free_count, full, empty, double_rel_err} !==
        {1'b1, 3'd0, 4'd8, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset: valid=%0b idx=%0d cnt=%0d full=%0b empty=%0b err=%0b, want 1 0 8 1 0 0",
               alloc_valid, alloc_index, free_count, full, empty, double_rel_err);
    end
    @(negedge clk);
    alloc_ready = 1'b0;
    release_valid = '0;
    rst = 1'b0;
    m_bm = '1;
    m_err = 1'b0;
  endtask

  task automatic test_soak();
    int bad = 0;
    logic fl, ar;
    logic [1:0] rv;
    for (int c = 0; c < 10000; c++) begin
      checks++;
      if (alloc_valid !== (m_bm != 0) || alloc_index !== IW'(m_lowest(m_bm)) ||
          free_count !== CW'(m_count(m_bm)) || full !== (m_bm == '1) ||
          empty !== (m_bm == '0) || double_rel_err !== m_err) begin
        failures++;
        bad++;
        if (bad <= 10)
          $display("FAIL soak cycle %0d: valid=%0b idx=%0d cnt=%0d err=%0b, want model bm=%b err=%0b",
                   c, alloc_valid, alloc_index, free_count, double_rel_err, m_bm, m_err);
      end
      fl = ($urandom_range(63) == 0);
      ar = $urandom_range(1);
      rv = fl ? 2'b00 : 2'($urandom_range(3));
      tick(fl, ar, rv, 3'($urandom_range(7)), 3'($urandom_range(7)));
    end
  endtask

  initial begin
    m_bm = '1;
    m_err = 1'b0;
    test_reset();
    test_drain();
    test_dual_release();
    test_alloc_release_same();
    test_double_release();
    test_flush();
    test_async_reset();
    test_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
